// File: rtl/seg7_pkg.sv
// Shared seven-segment pattern table and types for the display decoder and the reader.
// Patterns are active-low, bit 6 = a ... bit 0 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_ERR   = 4'hF;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage : seg7_pkg

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the display table: segment pattern -> {legal, is_blank, digit}.
// Anything not in the table reports digit = BCD_ERR with legal and is_blank both low.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       legal_o,
  output logic       is_blank_o,
  output logic [3:0] digit_o
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    legal_o    = 1'b1;
    is_blank_o = 1'b0;
    digit_o    = BCD_ERR;
    case (pattern_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: begin
        legal_o    = 1'b0;
        is_blank_o = 1'b1;
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule : seg7_pattern_decode

// File: rtl/seg7_reader.sv
// Receive side of the seven-segment link: synchronizes and debounces the segment bus,
// decodes each settled pattern once and offers it on a valid/ready output register.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output logic [3:0] out_bcd_o,
  output logic       out_err_o,
  output logic       blank_o,
  output logic       overrun_o
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  logic [6:0]       sync1_q, s_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_bcd_q, out_bcd_d;
  logic             out_err_q, out_err_d;
  logic             blank_q, blank_d;
  logic             overrun_q, overrun_d;

  logic             same, accept, emit;
  logic             dec_legal, dec_blank;
  logic [3:0]       dec_digit;

  seg7_pattern_decode u_decode (
    .pattern_i  (s_q),
    .legal_o    (dec_legal),
    .is_blank_o (dec_blank),
    .digit_o    (dec_digit)
  );

  assign same = (s_q == prev_q);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (same && (cnt_q == CNT_LAST)) begin
          accept  = 1'b1;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!same) state_d = ST_SETTLE;
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // Saturate at STABLE_CYCLES so a long-held pattern never wraps back onto the accept value.
  always_comb begin
    cnt_d = '0;
    if (same) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // A blank accept only updates the blank level; it never produces a result.
  assign emit = accept && !dec_blank;

  always_comb begin
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_err_d   = out_err_q;
    blank_d     = blank_q;
    overrun_d   = overrun_q;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (emit) begin
      out_valid_d = 1'b1;
      out_bcd_d   = dec_legal ? dec_digit : BCD_ERR;
      out_err_d   = !dec_legal;
      if (out_valid_q && !out_ready_i) overrun_d = 1'b1;
    end
    if (accept) begin
      blank_d = dec_blank;
    end else if (state_q == ST_LOCKED && !same) begin
      blank_d = 1'b0;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= SEG_BLANK;
      s_q         <= SEG_BLANK;
      prev_q      <= SEG_BLANK;
      cnt_q       <= '0;
      state_q     <= ST_SETTLE;
      out_valid_q <= 1'b0;
      out_bcd_q   <= 4'd0;
      out_err_q   <= 1'b0;
      blank_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= seg_i;
      s_q         <= sync1_q;
      prev_q      <= s_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_err_q   <= out_err_d;
      blank_q     <= blank_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_bcd_o   = out_bcd_q;
  assign out_err_o   = out_err_q;
  assign blank_o     = blank_q;
  assign overrun_o   = overrun_q;

endmodule : seg7_reader

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader with STABLE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_bcd;
  logic       out_err;
  logic       blank;
  logic       overrun;

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] codes [10];

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_i       (seg),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_bcd_o   (out_bcd),
    .out_err_o   (out_err),
    .blank_o     (blank),
    .overrun_o   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_bcd"},   32'(out_bcd),   32'd0);
    check({tag, ".out_err"},   32'(out_err),   32'd0);
    check({tag, ".blank"},     32'(blank),     32'd0);
    check({tag, ".overrun"},   32'(overrun),   32'd0);
  endtask

  // Apply a pattern with out_ready high: no result for six falling edges, a one-cycle
  // out_valid pulse on the seventh (accept at the sixth rising edge after the change), gone on the eighth.
  task automatic expect_pulse(input string tag, input logic [6:0] pat,
                              input logic [3:0] bcd, input logic err);
    seg = pat;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("%s.quiet%0d", tag, k), 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".bcd"},   32'(out_bcd),   32'(bcd));
    check({tag, ".err"},   32'(out_err),   32'(err));
    check({tag, ".blank"}, 32'(blank),     32'd0);
    @(negedge clk);
    check({tag, ".drop"},  32'(out_valid), 32'd0);
  endtask

  initial begin
    codes[0] = 7'b0000001; codes[1] = 7'b1001111; codes[2] = 7'b0010010;
    codes[3] = 7'b0000110; codes[4] = 7'b1001100; codes[5] = 7'b0100100;
    codes[6] = 7'b0100000; codes[7] = 7'b0001111; codes[8] = 7'b0000000;
    codes[9] = 7'b0000100;

    // Reset with the bus idle (blank).
    rst = 1'b1; seg = 7'b1111111; out_ready = 1'b0;
    wait_neg(2);
    check_reset_values("reset");
    rst = 1'b0;
    wait_neg(8);
    check("idle.blank", 32'(blank),     32'd1);
    check("idle.valid", 32'(out_valid), 32'd0);

    // Single digit 2: exact latency and a single pulse.
    out_ready = 1'b1;
    expect_pulse("dig2", 7'b0010010, 4'd2, 1'b0);
    wait_neg(2);
    check("dig2.no_repeat", 32'(out_valid), 32'd0);

    // All ten legal codes in order.
    for (int d = 0; d < 10; d++)
      expect_pulse($sformatf("walk%0d", d), codes[d], 4'(d), 1'b0);
    check("walk.overrun", 32'(overrun), 32'd0);

    // Illegal pattern, then blank.
    expect_pulse("illegal", 7'b0110110, 4'hF, 1'b1);
    seg = 7'b1111111;
    wait_neg(6);
    check("blank.before", 32'(blank), 32'd0);
    wait_neg(1);
    check("blank.level", 32'(blank),     32'd1);
    check("blank.valid", 32'(out_valid), 32'd0);
    wait_neg(2);
    check("blank.still_no_valid", 32'(out_valid), 32'd0);

    // Overrun: 8 then 0 with nobody consuming.
    out_ready = 1'b0;
    seg = 7'b0000000;
    wait_neg(7);
    check("ovr.first_valid", 32'(out_valid), 32'd1);
    check("ovr.first_bcd",   32'(out_bcd),   32'd8);
    seg = 7'b0000001;
    wait_neg(6);
    check("ovr.before",      32'(overrun),   32'd0);
    check("ovr.held_bcd",    32'(out_bcd),   32'd8);
    wait_neg(1);
    check("ovr.second_valid", 32'(out_valid), 32'd1);
    check("ovr.second_bcd",   32'(out_bcd),   32'd0);
    check("ovr.second_err",   32'(out_err),   32'd0);
    check("ovr.sticky_set",   32'(overrun),   32'd1);
    out_ready = 1'b1;
    wait_neg(1);
    out_ready = 1'b0;
    check("ovr.consumed",     32'(out_valid), 32'd0);
    check("ovr.sticky_hold",  32'(overrun),   32'd1);
    wait_neg(2);
    check("ovr.stays_clear",  32'(out_valid), 32'd0);

    // Two-cycle glitch on a locked 7: no result for 8, 7 emitted again.
    out_ready = 1'b1;
    expect_pulse("lock7", 7'b0001111, 4'd7, 1'b0);
    wait_neg(3);
    seg = 7'b0000000;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check($sformatf("glitch.quiet%0d", k), 32'(out_valid), 32'd0);
    end
    expect_pulse("reemit7", 7'b0001111, 4'd7, 1'b0);

    // Reset two cycles after a new pattern appears.
    seg = 7'b0000110;
    wait_neg(2);
    rst = 1'b1;
    wait_neg(2);
    check_reset_values("midreset");
    rst = 1'b0;
    expect_pulse("postreset3", 7'b0000110, 4'd3, 1'b0);
    check("postreset.overrun", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_seg7_reader
